// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control unit.
// Holds the state encodings, the opcode and funct constants, the ALUOp
// classes seen by the ALU control decoder, the ALUSrcB/PCSource select codes,
// the opcode class enum produced by mips_opcode_class, and the packed bundle
// of datapath strobes that the control FSM drives.
// Optional feature macro: MIPS_JR_EN (adds the JR_EXEC state and the JR class).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // FSM state encodings. FETCH must stay at zero because it is the reset
    // encoding. Codes 13..15 are unused and recover to FETCH. JR_EXEC (12)
    // only has behaviour when MIPS_JR_EN is defined; otherwise it is unused.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JR_EXEC   = 4'd12
    } state_e;

    // Primary opcodes, instruction[31:26].
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // funct field of the R-type jump-register instruction.
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALUOp classes consumed by the ALU control decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // Instruction class resolved in DECODE.
    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_RTYPE,
        CLS_BEQ,
        CLS_JUMP,
        CLS_ADDI,
        CLS_JR,
        CLS_ILLEGAL
    } op_class_e;

    // Datapath strobes driven from the state register.
    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_t;

endpackage

// File: rtl/mips_opcode_class.sv
// -----------------------------------------------------------------------------
// mips_opcode_class
// Combinational opcode-to-class decode for the main control FSM.
// Ports:
//   opcode_i   [5:0]  instruction[31:26]
//   funct_i    [5:0]  instruction[5:0], only looked at when MIPS_JR_EN is set
//   opClass_o         resolved instruction class
//   illegal_o         high when the opcode is not supported
// Optional feature macro: MIPS_JR_EN (R-type with funct JR becomes CLS_JR).
// -----------------------------------------------------------------------------
module mips_opcode_class
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output op_class_e  opClass_o,
    output logic       illegal_o
);

    // Map each supported opcode to its class; everything else is illegal.
    // Loads and stores share one class because they share the address step.
    always_comb begin
        opClass_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_LW, OP_SW: opClass_o = CLS_MEM;
            OP_RTYPE: begin
                opClass_o = CLS_RTYPE;
`ifdef MIPS_JR_EN
                if (funct_i == FUNCT_JR) begin
                    opClass_o = CLS_JR;
                end
`endif
            end
            OP_BEQ:  opClass_o = CLS_BEQ;
            OP_J:    opClass_o = CLS_JUMP;
            OP_ADDI: opClass_o = CLS_ADDI;
            default: opClass_o = CLS_ILLEGAL;
        endcase
    end

    assign illegal_o = (opClass_o == CLS_ILLEGAL);

`ifndef MIPS_JR_EN
    // Without JR support the funct field has no effect on the class.
    logic unusedFunct;
    assign unusedFunct = ^funct_i;
`endif

endmodule

// File: rtl/mips_multicycle_control.sv
// -----------------------------------------------------------------------------
// mips_multicycle_control
// Moore main control FSM for the multi-cycle MIPS datapath. Sequences fetch,
// decode, execute, memory and writeback and drives the datapath strobes plus
// the 2-bit ALUOp class used by the ALU control decoder.
// Ports:
//   clk, reset (async, active-high; forces FETCH and zeroes all strobes)
//   opcode[5:0], funct[5:0]  instruction fields from the IR
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//   illegal_op               one-cycle pulse in DECODE for unsupported opcodes
//   state[STATE_W-1:0]       current state, debug only
// Optional feature macro: MIPS_JR_EN (adds JR_EXEC for R-type funct 001000).
// -----------------------------------------------------------------------------
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    op_class_e          opClass;
    logic               opIllegal;
    ctrl_t              ctrl;

    mips_opcode_class u_opcode_class (
        .opcode_i  (opcode),
        .funct_i   (funct),
        .opClass_o (opClass),
        .illegal_o (opIllegal)
    );

    // State register. Reset is asynchronous so an in-flight instruction is
    // abandoned immediately and no later memory or register write happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The IR is stable from DECODE onwards, so opcode is
    // read directly in DECODE and MEM_ADDR. Writeback, store, branch, jump
    // and any unused encoding all fall through to FETCH.
    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH): state_d = STATE_W'(S_DECODE);
            STATE_W'(S_DECODE): begin
                case (opClass)
                    CLS_MEM:   state_d = STATE_W'(S_MEM_ADDR);
                    CLS_RTYPE: state_d = STATE_W'(S_R_EXEC);
                    CLS_BEQ:   state_d = STATE_W'(S_BRANCH);
                    CLS_JUMP:  state_d = STATE_W'(S_JUMP);
                    CLS_ADDI:  state_d = STATE_W'(S_ADDI_EXEC);
`ifdef MIPS_JR_EN
                    CLS_JR:    state_d = STATE_W'(S_JR_EXEC);
`endif
                    default:   state_d = STATE_W'(S_FETCH);
                endcase
            end
            STATE_W'(S_MEM_ADDR): begin
                state_d = (opcode == OP_SW) ? STATE_W'(S_MEM_WRITE)
                                            : STATE_W'(S_MEM_READ);
            end
            STATE_W'(S_MEM_READ):  state_d = STATE_W'(S_MEM_WB);
            STATE_W'(S_R_EXEC):    state_d = STATE_W'(S_R_WB);
            STATE_W'(S_ADDI_EXEC): state_d = STATE_W'(S_ADDI_WB);
            default:               state_d = STATE_W'(S_FETCH);
        endcase
    end

    // Output decode from the state register only. While reset is high the
    // state reads FETCH, but every strobe is held low so the datapath idles.
    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                STATE_W'(S_FETCH): begin
                    ctrl.memRead  = 1'b1;
                    ctrl.irWrite  = 1'b1;
                    ctrl.aluSrcB  = SRCB_FOUR;
                    ctrl.aluOp    = ALUOP_ADD;
                    ctrl.pcSource = PCSRC_ALU;
                    ctrl.pcWrite  = 1'b1;
                end
                STATE_W'(S_DECODE): begin
                    ctrl.aluSrcB = SRCB_IMM_SH2;
                    ctrl.aluOp   = ALUOP_ADD;
                    illegal_op   = opIllegal;
                end
                STATE_W'(S_MEM_ADDR), STATE_W'(S_ADDI_EXEC): begin
                    ctrl.aluSrcA = 1'b1;
                    ctrl.aluSrcB = SRCB_IMM;
                    ctrl.aluOp   = ALUOP_ADD;
                end
                STATE_W'(S_MEM_READ): begin
                    ctrl.memRead = 1'b1;
                    ctrl.iOrD    = 1'b1;
                end
                STATE_W'(S_MEM_WB): begin
                    ctrl.regWrite = 1'b1;
                    ctrl.memToReg = 1'b1;
                end
                STATE_W'(S_MEM_WRITE): begin
                    ctrl.memWrite = 1'b1;
                    ctrl.iOrD     = 1'b1;
                end
                STATE_W'(S_R_EXEC): begin
                    ctrl.aluSrcA = 1'b1;
                    ctrl.aluSrcB = SRCB_REG;
                    ctrl.aluOp   = ALUOP_FUNCT;
                end
                STATE_W'(S_R_WB): begin
                    ctrl.regWrite = 1'b1;
                    ctrl.regDst   = 1'b1;
                end
                STATE_W'(S_ADDI_WB): begin
                    ctrl.regWrite = 1'b1;
                end
                STATE_W'(S_BRANCH): begin
                    ctrl.aluSrcA     = 1'b1;
                    ctrl.aluSrcB     = SRCB_REG;
                    ctrl.aluOp       = ALUOP_SUB;
                    ctrl.pcWriteCond = 1'b1;
                    ctrl.pcSource    = PCSRC_ALUOUT;
                end
                STATE_W'(S_JUMP): begin
                    ctrl.pcWrite  = 1'b1;
                    ctrl.pcSource = PCSRC_JUMP;
                end
`ifdef MIPS_JR_EN
                STATE_W'(S_JR_EXEC): begin
                    ctrl.pcWrite  = 1'b1;
                    ctrl.pcSource = PCSRC_REGA;
                end
`endif
                default: ctrl = '0;
            endcase
        end
    end

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iOrD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign MemtoReg    = ctrl.memToReg;
    assign IRWrite     = ctrl.irWrite;
    assign RegDst      = ctrl.regDst;
    assign RegWrite    = ctrl.regWrite;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign state       = state_q;

endmodule
